// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states
// and the byte-lane mask used by the read-modify-write merge.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } state_e;

    // Lanes that a store of the given size replaces in the addressed word.
    function automatic logic [31:0] size_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            SZ_BYTE: m = 32'h0000_00FF;
            SZ_HALF: m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory pins of the memory access unit.
// master = the unit, slave = the CPU datapath and memory around it.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output MemRead, MemWrite, mem_addr, mem_wd,
        input  mem_rd
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  MemRead, MemWrite, mem_addr, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/mau_load_ext.sv
// Extracts the low byte/half of a word and sign- or zero-extends it;
// word size passes the input through unchanged.
module mau_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (size)
            SZ_BYTE: data_out = {{24{~zext & data_in[7]}},  data_in[7:0]};
            SZ_HALF: data_out = {{16{~zext & data_in[15]}}, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store initiator for a byte-addressed, word-writing memory.
// Sub-word stores go through read-modify-write; all outputs decode from registers.
//
//   state    | meaning
//   IDLE     | ready for a request; latch it and classify on accept
//   READ     | load: MemRead, capture extended read data
//   RMW_READ | sub-word store: MemRead, merge new lanes into the read word
//   WRITE    | MemWrite with the final word
//   RESP     | one-cycle response pulse
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
)
(
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.master bus
);

    localparam logic [32:0] ADDR_LAST = 33'(MEM_BYTES - 4);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [31:0] ext_in;
    logic        ext_zext;
    logic [31:0] ext_out;
    logic [31:0] merged;

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == SZ_ILL)
            req_err = 1'b1;
        if (bus.req_size == SZ_HALF && bus.req_addr[0])
            req_err = 1'b1;
        if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if ({1'b0, bus.req_addr} > ADDR_LAST)
            req_err = 1'b1;
    end

    // In RMW_READ the extender zero-extends the store data so it lands in
    // exactly the lanes cleared by the size mask.
    assign ext_in   = (state_q == RMW_READ) ? data_q : bus.mem_rd;
    assign ext_zext = (state_q == RMW_READ) ? 1'b1   : uns_q;

    mau_load_ext u_ext (
        .data_in  (ext_in),
        .size     (size_q),
        .zext     (ext_zext),
        .data_out (ext_out)
    );

    assign merged = (bus.mem_rd & ~size_mask(size_q)) | ext_out;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    size_d = bus.req_size;
                    uns_d  = bus.req_unsigned;
                    addr_d = bus.req_addr;
                    data_d = bus.req_wdata;
                    err_d  = req_err;
                    if (req_err)
                        state_d = RESP;
                    else if (!bus.req_we)
                        state_d = READ;
                    else if (bus.req_size == SZ_WORD)
                        state_d = WRITE;
                    else
                        state_d = RMW_READ;
                end
            end
            READ: begin
                data_d  = ext_out;
                state_d = RESP;
            end
            RMW_READ: begin
                data_d  = merged;
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wd     = '0;
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            READ, RMW_READ: begin
                bus.MemRead  = 1'b1;
                bus.mem_addr = addr_q;
            end
            WRITE: begin
                bus.MemWrite = 1'b1;
                bus.mem_addr = addr_q;
                bus.mem_wd   = data_q;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (!we_q && !err_q) ? data_q : 32'h0;
            end
            default: ;
        endcase
    end

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.MemRead && bus.MemWrite));

    a_write_only_clean_store: assert property (@(posedge clk) disable iff (!rst_n)
        bus.MemWrite |-> (we_q && !err_q));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array memory model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:MEM_BYTES-1];

    always_comb begin
        bus.mem_rd = '0;
        if (bus.MemRead)
            for (int i = 0; i < 4; i++)
                if (bus.mem_addr + 32'(i) < 32'(MEM_BYTES))
                    bus.mem_rd[8*i +: 8] = mem[10'(bus.mem_addr + 32'(i))];
    end

    always @(posedge clk)
        if (bus.MemWrite)
            for (int i = 0; i < 4; i++)
                if (bus.mem_addr + 32'(i) < 32'(MEM_BYTES))
                    mem[10'(bus.mem_addr + 32'(i))] = bus.mem_wd[8*i +: 8];

    function automatic logic [31:0] peek(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // Issues one request from IDLE and observes it until the response pulse.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nrd, output int nwr,
                          output logic [31:0] wdat, output logic [31:0] wadr,
                          output logic tout);
        lat = 0; rd = 'x; er = 1'bx; nrd = 0; nwr = 0; wdat = 'x; wadr = 'x; tout = 1'b1;
        for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (bus.MemRead) nrd++;
            if (bus.MemWrite) begin nwr++; wdat = bus.mem_wd; wadr = bus.mem_addr; end
            if (bus.resp_valid) begin
                rd = bus.resp_rdata; er = bus.resp_err; tout = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_WORD;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #3;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.req_ready); end
        total++; if ({bus.MemRead, bus.MemWrite, bus.resp_valid, bus.resp_err} !== 4'b0)
            begin bad++; $display("FAIL rst_ctl got=%b want=0000", {bus.MemRead, bus.MemWrite, bus.resp_valid, bus.resp_err}); end
        total++; if ({bus.mem_addr, bus.mem_wd, bus.resp_rdata} !== 96'h0)
            begin bad++; $display("FAIL rst_data got=%h/%h/%h want=0", bus.mem_addr, bus.mem_wd, bus.resp_rdata); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_word_store_load();
        int lat, nrd, nwr; logic [31:0] rd, wdat, wadr; logic er, tout;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nrd, nwr, wdat, wadr, tout);
        total++; if (tout !== 1'b0) begin bad++; $display("FAIL ws_timeout got=%b want=0", tout); end
        total++; if ({er, rd} !== 33'h0) begin bad++; $display("FAIL ws_resp got=%b/%h want=0/0", er, rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL ws_lat got=%0d want=2", lat); end
        total++; if (nwr !== 1 || nrd !== 0) begin bad++; $display("FAIL ws_pulses got=wr%0d rd%0d want=wr1 rd0", nwr, nrd); end
        total++; if (wadr !== 32'h10 || wdat !== 32'hDEADBEEF)
            begin bad++; $display("FAIL ws_pins got=%h@%h want=deadbeef@10", wdat, wadr); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, nrd, nwr, wdat, wadr, tout);
        total++; if (tout !== 1'b0 || er !== 1'b0 || rd !== 32'hDEADBEEF)
            begin bad++; $display("FAIL wl_resp got=%h err=%b tout=%b want=deadbeef err=0", rd, er, tout); end
        total++; if (lat !== 2 || nrd !== 1 || nwr !== 0)
            begin bad++; $display("FAIL wl_timing got=lat%0d rd%0d wr%0d want=lat2 rd1 wr0", lat, nrd, nwr); end
    endtask

    task automatic test_byte_store_rmw();
        int lat, nrd, nwr; logic [31:0] rd, wdat, wadr; logic er, tout;
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h123456A5, lat, rd, er, nrd, nwr, wdat, wadr, tout);
        total++; if (tout !== 1'b0 || er !== 1'b0 || rd !== 32'h0)
            begin bad++; $display("FAIL bs_resp got=%h err=%b tout=%b want=0 err=0", rd, er, tout); end
        total++; if (lat !== 3 || nrd !== 1 || nwr !== 1)
            begin bad++; $display("FAIL bs_timing got=lat%0d rd%0d wr%0d want=lat3 rd1 wr1", lat, nrd, nwr); end
        total++; if (wadr !== 32'h11 || wdat[23:0] !== 24'hDEADA5)
            begin bad++; $display("FAIL bs_pins got=%h@%h want=??deada5@11", wdat, wadr); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, nrd, nwr, wdat, wadr, tout);
        total++; if (rd !== 32'hDEADA5EF || er !== 1'b0)
            begin bad++; $display("FAIL bs_readback got=%h err=%b want=deada5ef err=0", rd, er); end
    endtask

    task automatic test_subword_loads();
        logic [1:0]  sz [4] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4] = '{32'h11, 32'h11, 32'h10, 32'h10};
        logic [31:0] ex [4] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFA5EF, 32'h0000A5EF};
        int lat, nrd, nwr; logic [31:0] rd, wdat, wadr; logic er, tout;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, nrd, nwr, wdat, wadr, tout);
            total++; if (rd !== ex[i] || er !== 1'b0 || lat !== 2)
                begin bad++; $display("FAIL subload%0d got=%h err=%b lat=%0d want=%h err=0 lat=2", i, rd, er, lat, ex[i]); end
        end
    endtask

    task automatic test_errors();
        logic        we [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [5] = '{SZ_WORD, SZ_HALF, SZ_WORD, SZ_ILL, SZ_BYTE};
        logic [31:0] ad [5] = '{32'h12, 32'h13, 32'd1021, 32'h0, 32'd1021};
        int lat, nrd, nwr; logic [31:0] rd, wdat, wadr; logic er, tout;
        for (int i = 0; i < 5; i++) begin
            do_req(we[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, lat, rd, er, nrd, nwr, wdat, wadr, tout);
            total++; if (tout !== 1'b0 || er !== 1'b1 || rd !== 32'h0)
                begin bad++; $display("FAIL err%0d_resp got=%h err=%b tout=%b want=0 err=1", i, rd, er, tout); end
            total++; if (lat !== 1 || nrd !== 0 || nwr !== 0)
                begin bad++; $display("FAIL err%0d_timing got=lat%0d rd%0d wr%0d want=lat1 rd0 wr0", i, lat, nrd, nwr); end
        end
        total++; if (peek(1020) !== 32'h0) begin bad++; $display("FAIL err_mem_top got=%h want=0", peek(1020)); end
    endtask

    task automatic test_boundary_store();
        int lat, nrd, nwr; logic [31:0] rd, wdat, wadr; logic er, tout;
        do_req(1'b1, SZ_BYTE, 1'b0, 32'd1020, 32'h0000005A, lat, rd, er, nrd, nwr, wdat, wadr, tout);
        total++; if (er !== 1'b0 || lat !== 3 || nwr !== 1 || wadr !== 32'd1020)
            begin bad++; $display("FAIL edge_store got=err%b lat%0d wr%0d @%h want=err0 lat3 wr1 @3fc", er, lat, nwr, wadr); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'd1020, 32'h0, lat, rd, er, nrd, nwr, wdat, wadr, tout);
        total++; if (rd !== 32'h0000005A || er !== 1'b0)
            begin bad++; $display("FAIL edge_readback got=%h err=%b want=0000005a err=0", rd, er); end
    endtask

    task automatic test_reset_mid_rmw();
        int lat, nrd, nwr, nresp; logic [31:0] rd, wdat, wadr; logic er, tout;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, lat, rd, er, nrd, nwr, wdat, wadr, tout);
        bus.req_we = 1'b1; bus.req_size = SZ_BYTE; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h000000FF; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.MemRead !== 1'b1) begin bad++; $display("FAIL rmw_in_read got=%b want=1", bus.MemRead); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 || bus.req_ready !== 1'b1)
            begin bad++; $display("FAIL rmw_async got=rd%b wr%b rdy%b want=rd0 wr0 rdy1", bus.MemRead, bus.MemWrite, bus.req_ready); end
        #1 rst_n = 1'b1;
        nwr = 0; nresp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.MemWrite) nwr++;
            if (bus.resp_valid) nresp++;
        end
        total++; if (nwr !== 0 || nresp !== 0)
            begin bad++; $display("FAIL rmw_abort got=wr%0d resp%0d want=wr0 resp0", nwr, nresp); end
        total++; if (peek(32'h20) !== 32'h11223344 || bus.req_ready !== 1'b1)
            begin bad++; $display("FAIL rmw_mem got=%h rdy=%b want=11223344 rdy=1", peek(32'h20), bus.req_ready); end
    endtask

    task automatic test_back_to_back();
        int edge_n = 0, acc = 0, nresp = 0;
        logic [31:0] r [2] = '{32'hx, 32'hx};
        logic rdy;
        bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_size = SZ_BYTE; bus.req_unsigned = 1'b1; bus.req_addr = 32'h11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (nresp < 2) r[nresp] = bus.resp_rdata;
                nresp++;
            end
            rdy = bus.req_ready;
            @(posedge clk);
            edge_n++;
            if (rdy && acc == 0) begin acc = edge_n; #1 bus.req_valid = 1'b0; end
        end
        bus.req_valid = 1'b0;
        total++; if (acc !== 3) begin bad++; $display("FAIL b2b_accept got=%0d want=3", acc); end
        total++; if (nresp !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", nresp); end
        total++; if (r[0] !== 32'hDEADA5EF || r[1] !== 32'h000000A5)
            begin bad++; $display("FAIL b2b_data got=%h,%h want=deada5ef,000000a5", r[0], r[1]); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        test_reset();
        test_word_store_load();
        test_byte_store_rmw();
        test_subword_loads();
        test_errors();
        test_boundary_store();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
